// File: rtl/booth_mult_sequencer.sv
// Sequential radix-4 Booth multiplier: WIDTH x WIDTH signed, low WIDTH bits plus overflow flag.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the iterations and goes straight to DONE.
module booth_mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH / 2,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [2:0]       current_three_bits,
  input  logic             shift_multiplicand,
  input  logic             do_nothing,
  input  logic [4:0]       ctrl_ALUopcode,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH+1:0] m_reg;
  logic [WIDTH+1:0] acc_reg;
  logic [WIDTH-1:0] mq_reg;
  logic             q_1_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             exception_reg;
  logic             rdy_reg;
  logic             busy_reg;

  logic [WIDTH+1:0] mx;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] acc_next;
  logic [WIDTH+1:0] sign_copies;
  logic             sub;
  logic             last_iter;
  logic             zero_op;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (data_operandA == '0) || (data_operandB == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Product fits in WIDTH bits only if every accumulator bit repeats the low word's sign.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH + 2; gi++) begin : g_sign
      assign sign_copies[gi] = mq_reg[WIDTH-1];
    end
  endgenerate

  always_comb begin
    mx       = shift_multiplicand ? {m_reg[WIDTH:0], 1'b0} : m_reg;
    addend   = do_nothing ? '0 : mx;
    sub      = (ctrl_ALUopcode == 5'b00001);
    acc_next = sub ? (acc_reg - addend) : (acc_reg + addend);
  end

  assign last_iter          = (cnt_reg == CNT_W'(ITERS - 1));
  assign current_three_bits = {mq_reg[1], mq_reg[0], q_1_reg};
  assign data_result        = result_reg;
  assign data_exception     = exception_reg;
  assign data_resultRDY     = rdy_reg;
  assign busy               = busy_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      m_reg         <= '0;
      acc_reg       <= '0;
      mq_reg        <= '0;
      q_1_reg       <= 1'b0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      exception_reg <= 1'b0;
      rdy_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      rdy_reg <= 1'b0;
      if (ctrl_MULT) begin
        // A start in any state abandons whatever was in flight.
        m_reg     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
        acc_reg   <= '0;
        mq_reg    <= zero_op ? '0 : data_operandB;
        q_1_reg   <= 1'b0;
        cnt_reg   <= '0;
        state_reg <= zero_op ? DONE : RUN;
        busy_reg  <= !zero_op;
      end else begin
        case (state_reg)
          RUN: begin
            q_1_reg <= mq_reg[1];
            mq_reg  <= {acc_next[1:0], mq_reg[WIDTH-1:2]};
            acc_reg <= {{2{acc_next[WIDTH+1]}}, acc_next[WIDTH+1:2]};
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_iter) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
            end
          end
          DONE: begin
            result_reg    <= mq_reg;
            exception_reg <= (acc_reg != sign_copies);
            rdy_reg       <= 1'b1;
            state_reg     <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: radix-4 decoder model plus a 64-bit arithmetic product reference.
module tb_booth_mult_sequencer;

  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH / 2;
`ifdef MULT_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [2:0]       current_three_bits;
  logic             shift_multiplicand;
  logic             do_nothing;
  logic [4:0]       ctrl_ALUopcode;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  booth_mult_sequencer #(.WIDTH(WIDTH), .ITERS(ITERS), .CNT_W(5)) dut (
    .clock              (clock),
    .reset              (reset),
    .ctrl_MULT          (ctrl_MULT),
    .data_operandA      (data_operandA),
    .data_operandB      (data_operandB),
    .current_three_bits (current_three_bits),
    .shift_multiplicand (shift_multiplicand),
    .do_nothing         (do_nothing),
    .ctrl_ALUopcode     (ctrl_ALUopcode),
    .data_result        (data_result),
    .data_exception     (data_exception),
    .data_resultRDY     (data_resultRDY),
    .busy               (busy)
  );

  // Radix-4 Booth recoding table: window value -> {0, +M, +2M, -2M, -M}.
  always_comb begin
    shift_multiplicand = 1'b0;
    do_nothing         = 1'b0;
    ctrl_ALUopcode     = 5'b00000;
    case (current_three_bits)
      3'b000, 3'b111: do_nothing = 1'b1;
      3'b011:         shift_multiplicand = 1'b1;
      3'b100: begin
        shift_multiplicand = 1'b1;
        ctrl_ALUopcode     = 5'b00001;
      end
      3'b101, 3'b110: ctrl_ALUopcode = 5'b00001;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = int'(p[31:0]);
    r  = p[31:0];
    e  = (longint'(lo) != p);
  endfunction

  // Entered and left just after a rising edge; operands are scrambled once sampled.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input int window, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= window; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r;
    logic        exp_e;
    bit          bypassed;
    int          lat;
    int          pulses;
    model(a, b, exp_r, exp_e);
    bypassed = BYPASS && (a == 0 || b == 0);
    start(a, b);
    check({tag, " busy"}, 64'(busy), bypassed ? 64'd0 : 64'd1);
    if (!bypassed) check({tag, " window"}, 64'(current_three_bits), 64'({b[1], b[0], 1'b0}));
    wait_rdy(25, lat, pulses);
    check({tag, " latency"}, 64'(lat), bypassed ? 64'd1 : 64'(ITERS + 1));
    check({tag, " rdy_pulses"}, 64'(pulses), 64'd1);
    check({tag, " result"}, 64'(data_result), 64'(exp_r));
    check({tag, " exception"}, 64'(data_exception), 64'(exp_e));
    $display("%s: A=%h B=%h -> result=%h exc=%0d latency=%0d", tag, a, b, data_result,
             data_exception, lat);
  endtask

  initial begin
    int          lat;
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset window", 64'(current_three_bits), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_mult("3x5", 32'd3, 32'd5);
    check("3x5 literal", 64'(data_result), 64'd15);
    run_mult("-7x6", 32'hFFFFFFF9, 32'd6);
    check("-7x6 literal", 64'(data_result), 64'hFFFFFFD6);
    run_mult("maxx2", 32'h7FFFFFFF, 32'd2);
    run_mult("minx-1", 32'h80000000, 32'hFFFFFFFF);
    run_mult("0x9", 32'd0, 32'd9);
    run_mult("9x0", 32'd9, 32'd0);

    // Restart mid-run: the abandoned op must not raise RDY.
    start(32'h00012345, 32'h00000010);
    wait_rdy(5, lat, pulses);
    check("restart early_rdy", 64'(pulses), 64'd0);
    start(32'd4, 32'hFFFFFFFD);
    wait_rdy(25, lat, pulses);
    check("restart latency", 64'(lat), 64'(ITERS + 1));
    check("restart rdy_pulses", 64'(pulses), 64'd1);
    check("restart result", 64'(data_result), 64'hFFFFFFF4);
    check("restart exception", 64'(data_exception), 64'd0);
    $display("restart: A=4 B=-3 -> result=%h latency=%0d", data_result, lat);

    // Reset during iteration 8.
    start(32'h00001234, 32'h00005678);
    wait_rdy(7, lat, pulses);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset result", 64'(data_result), 64'd0);
    check("midreset exception", 64'(data_exception), 64'd0);
    check("midreset rdy", 64'(data_resultRDY), 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset window", 64'(current_three_bits), 64'd0);
    wait_rdy(25, lat, pulses);
    check("midreset no_rdy", 64'(pulses + (lat < 0 ? 0 : 1)), 64'd0);
    $display("midreset: outputs cleared, rdy pulses after reset=%0d", pulses);
    run_mult("-1x-1", 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("-1x-1 literal", 64'(data_result), 64'd1);

    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
      run_mult($sformatf("rand%0d", i), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
